// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue register feeding the Execute-stage ALU.
// Decodes the ALU function code, selects operand A/B, and holds the result
// in an ID/EX register with a valid/ready handshake and a priority flush.
//
// ALU function encoding is {funct7[5], funct3} for the register-register
// ops: ADD=0000 SLL=0001 SLT=0010 SLTU=0011 XOR=0100 SRL=0101 OR=0110
// AND=0111 SUB=1000 SRA=1101.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_funct,
    output logic [XLEN-1:0] alu_op_a,
    output logic [XLEN-1:0] alu_op_b,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            is_branch,
    output logic [2:0]      br_funct3,
    output logic            illegal
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [31:0]     w_imm_i;
    logic [31:0]     w_imm_s;
    logic [31:0]     w_imm_u;

    // Decoded next-state values
    logic [3:0]      w_funct;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic            w_reg_write;
    logic            w_is_branch;
    logic [2:0]      w_br_funct3;
    logic            w_illegal;
    logic            w_writes_rd;
    logic            w_accept;

    // Registered ID/EX state
    logic            r_valid;
    logic [3:0]      r_funct;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_is_branch;
    logic [2:0]      r_br_funct3;
    logic            r_illegal;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_rd     = instr[11:7];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_u  = {instr[31:12], 12'h000};

    // The stage is never ready while held in reset.
    assign in_ready = rst_n & (~r_valid | out_ready);
    assign w_accept = in_valid & in_ready & ~flush;

    // Decode opcode/funct fields into ALU function, operands and control.
    always_comb begin
        w_funct     = ALU_ADD;
        w_op_a      = '0;
        w_op_b      = '0;
        w_is_branch = 1'b0;
        w_br_funct3 = 3'b000;
        w_illegal   = 1'b0;
        w_writes_rd = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_op_a      = rs1_data;
                w_op_b      = rs2_data;
                w_writes_rd = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    w_funct = {1'b0, w_funct3};
                end else if (w_funct7 == F7_ALT &&
                             (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                    w_funct = {1'b1, w_funct3};
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                w_op_a      = rs1_data;
                w_writes_rd = 1'b1;
                case (w_funct3)
                    3'b001: begin
                        w_op_b  = {27'd0, instr[24:20]};
                        w_funct = ALU_SLL;
                        if (w_funct7 != F7_BASE) begin
                            w_illegal = 1'b1;
                        end else begin
                            w_illegal = 1'b0;
                        end
                    end
                    3'b101: begin
                        w_op_b = {27'd0, instr[24:20]};
                        if (w_funct7 == F7_BASE) begin
                            w_funct = ALU_SRL;
                        end else if (w_funct7 == F7_ALT) begin
                            w_funct = ALU_SRA;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    default: begin
                        w_op_b  = w_imm_i;
                        w_funct = {1'b0, w_funct3};
                    end
                endcase
            end
            OPC_LOAD: begin
                w_op_a      = rs1_data;
                w_op_b      = w_imm_i;
                w_writes_rd = 1'b1;
            end
            OPC_STORE: begin
                w_op_a = rs1_data;
                w_op_b = w_imm_s;
            end
            OPC_BRANCH: begin
                w_op_a      = rs1_data;
                w_op_b      = rs2_data;
                w_is_branch = 1'b1;
                w_br_funct3 = w_funct3;
                case (w_funct3)
                    3'b000, 3'b001: w_funct = ALU_SUB;
                    3'b100, 3'b101: w_funct = ALU_SLT;
                    3'b110, 3'b111: w_funct = ALU_SLTU;
                    default:        w_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_op_b      = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                w_op_a      = pc;
                w_op_b      = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OPC_JAL: begin
                w_op_a      = pc;
                w_op_b      = 32'd4;
                w_writes_rd = 1'b1;
            end
            OPC_JALR: begin
                w_op_a      = pc;
                w_op_b      = 32'd4;
                w_writes_rd = 1'b1;
                if (w_funct3 != 3'b000) begin
                    w_illegal = 1'b1;
                end else begin
                    w_illegal = 1'b0;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase

        // Illegal instructions issue as a harmless ADD 0,0 with no side effects.
        if (w_illegal) begin
            w_funct     = ALU_ADD;
            w_op_a      = '0;
            w_op_b      = '0;
            w_is_branch = 1'b0;
            w_br_funct3 = 3'b000;
            w_reg_write = 1'b0;
        end else begin
            w_reg_write = w_writes_rd & (w_rd != 5'd0);
        end
    end

    // ID/EX register: flush beats accept, accept beats drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_funct     <= ALU_ADD;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_is_branch <= 1'b0;
            r_br_funct3 <= 3'b000;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_funct     <= w_funct;
            r_op_a      <= w_op_a;
            r_op_b      <= w_op_b;
            r_rd        <= w_rd;
            r_reg_write <= w_reg_write;
            r_is_branch <= w_is_branch;
            r_br_funct3 <= w_br_funct3;
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign out_valid = r_valid;
    assign alu_funct = r_funct;
    assign alu_op_a  = r_op_a;
    assign alu_op_b  = r_op_b;
    assign rd        = r_rd;
    assign reg_write = r_reg_write;
    assign is_branch = r_is_branch;
    assign br_funct3 = r_br_funct3;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_issue_stage;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef struct packed {
        logic [3:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
        logic        br;
        logic [2:0]  bf3;
        logic        ill;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data, alu_op_a, alu_op_b;
    logic [3:0]  alu_funct;
    logic [4:0]  rd;
    logic        reg_write, is_branch, illegal;
    logic [2:0]  br_funct3;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic chk_en   = 1'b0;
    logic mv       = 1'b0;
    dec_t md       = '0;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_funct(alu_funct), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .rd(rd), .reg_write(reg_write), .is_branch(is_branch),
        .br_funct3(br_funct3), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference decode: classify the instruction, decide legality, then
    // build operands from the RV32I rules with plain integer arithmetic.
    function automatic dec_t model_dec(input logic [31:0] ins, input logic [31:0] p,
                                       input logic [31:0] r1, input logic [31:0] r2);
        dec_t d;
        int   op = int'(ins[6:0]);
        int   f3 = int'(ins[14:12]);
        int   f7 = int'(ins[31:25]);
        int   immi = int'($signed(ins[31:20]));
        int   imms = int'($signed({ins[31:25], ins[11:7]}));
        int   immu = int'(ins[31:12]) * 4096;
        bit   ok = 1'b1;
        bit   writes = 1'b0;
        d = '0;
        d.rd = ins[11:7];
        d.funct = ALU_ADD;
        if (op == 'h33) begin
            writes = 1; d.a = r1; d.b = r2;
            if (f7 == 0) d.funct = 4'(f3);
            else if (f7 == 'h20 && f3 == 0) d.funct = ALU_SUB;
            else if (f7 == 'h20 && f3 == 5) d.funct = ALU_SRA;
            else ok = 0;
        end else if (op == 'h13) begin
            writes = 1; d.a = r1;
            if (f3 == 1 || f3 == 5) begin
                d.b = 32'(int'(ins[24:20]));
                if (f7 == 0) d.funct = (f3 == 1) ? ALU_SLL : ALU_SRL;
                else if (f7 == 'h20 && f3 == 5) d.funct = ALU_SRA;
                else ok = 0;
            end else begin
                d.b = 32'(immi); d.funct = 4'(f3);
            end
        end else if (op == 'h03) begin
            writes = 1; d.a = r1; d.b = 32'(immi);
        end else if (op == 'h23) begin
            d.a = r1; d.b = 32'(imms);
        end else if (op == 'h63) begin
            d.a = r1; d.b = r2; d.br = 1; d.bf3 = 3'(f3);
            if (f3 < 2) d.funct = ALU_SUB;
            else if (f3 == 4 || f3 == 5) d.funct = ALU_SLT;
            else if (f3 >= 6) d.funct = ALU_SLTU;
            else ok = 0;
        end else if (op == 'h37) begin
            writes = 1; d.b = 32'(immu);
        end else if (op == 'h17) begin
            writes = 1; d.a = p; d.b = 32'(immu);
        end else if (op == 'h6F || op == 'h67) begin
            writes = 1; d.a = p; d.b = 32'd4;
            if (op == 'h67 && f3 != 0) ok = 0;
        end else begin
            ok = 0;
        end
        if (!ok) begin
            d.funct = ALU_ADD; d.a = 32'd0; d.b = 32'd0; d.br = 1'b0; d.bf3 = 3'd0;
        end
        d.ill = !ok;
        d.wr  = ok && writes && (d.rd != 5'd0);
        return d;
    endfunction

    // One cycle of stimulus: drive inputs, advance the model across the edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl);
        logic nv;
        dec_t nd;
        in_valid = v; instr = ins; pc = p; rs1_data = a; rs2_data = b;
        out_ready = ordy; flush = fl;
        nv = mv; nd = md;
        if (fl) nv = 1'b0;
        else if (v && (!mv || ordy)) begin nv = 1'b1; nd = model_dec(ins, p, a, b); end
        else if (ordy) nv = 1'b0;
        @(posedge clk);
        #1;
        mv = nv; md = nd;
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!mv || out_ready)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
            if (mv) begin
                chk("alu_funct", {28'd0, alu_funct}, {28'd0, md.funct});
                chk("alu_op_a", alu_op_a, md.a);
                chk("alu_op_b", alu_op_b, md.b);
                chk("rd", {27'd0, rd}, {27'd0, md.rd});
                chk("reg_write", {31'd0, reg_write}, {31'd0, md.wr});
                chk("is_branch", {31'd0, is_branch}, {31'd0, md.br});
                chk("br_funct3", {29'd0, br_funct3}, {29'd0, md.bf3});
                chk("illegal", {31'd0, illegal}, {31'd0, md.ill});
            end
        end
    end

    logic [6:0] opc_tbl [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};

    initial begin
        dec_t       pin;
        logic [6:0] f7;
        rst_n = 1'b0; in_valid = 1'b0; instr = 32'd0; pc = 32'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_funct", {28'd0, alu_funct}, {28'd0, ALU_ADD});
        chk("rst_op_a", alu_op_a, 32'd0);
        chk("rst_op_b", alu_op_b, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Model pinning against hand-decoded encodings.
        pin = model_dec(32'h40208233, 32'd0, 32'd10, 32'd3);
        chk("model_sub", {28'd0, pin.funct}, {28'd0, ALU_SUB});
        pin = model_dec(32'h0020C463, 32'd0, 32'd1, 32'd2);
        chk("model_blt", {28'd0, pin.funct}, {28'd0, ALU_SLT});

        // sub x4,x1,x2
        cyc(1, 32'h40208233, 32'd0, 32'd10, 32'd3, 1, 0);
        chk("sub_valid", {31'd0, out_valid}, 32'd1);
        chk("sub_funct", {28'd0, alu_funct}, {28'd0, ALU_SUB});
        chk("sub_a", alu_op_a, 32'd10);
        chk("sub_b", alu_op_b, 32'd3);
        chk("sub_rd", {27'd0, rd}, 32'd4);
        chk("sub_wr", {31'd0, reg_write}, 32'd1);
        // srai x1,x1,3
        cyc(1, 32'h4030D093, 32'd0, 32'h80000000, 32'd0, 1, 0);
        chk("srai_funct", {28'd0, alu_funct}, {28'd0, ALU_SRA});
        chk("srai_b", alu_op_b, 32'd3);
        // addi x0,x0,-1
        cyc(1, 32'hFFF00013, 32'd0, 32'd0, 32'd0, 1, 0);
        chk("addi_b", alu_op_b, 32'hFFFFFFFF);
        chk("addi_wr", {31'd0, reg_write}, 32'd0);

        // Stall: hold add x3,x1,x2 for three cycles while sub waits.
        cyc(1, 32'h002081B3, 32'd0, 32'd5, 32'd6, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h40208233, 32'd0, 32'd20, 32'd7, 0, 0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_a", alu_op_a, 32'd5);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        cyc(1, 32'h40208233, 32'd0, 32'd20, 32'd7, 1, 0);
        chk("unstall_funct", {28'd0, alu_funct}, {28'd0, ALU_SUB});
        chk("unstall_a", alu_op_a, 32'd20);
        cyc(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        chk("no_dup_valid", {31'd0, out_valid}, 32'd0);

        // Flush while holding, with a simultaneous incoming instruction.
        cyc(1, 32'h002081B3, 32'd0, 32'd1, 32'd1, 1, 0);
        cyc(1, 32'h40208233, 32'd0, 32'd9, 32'd9, 0, 0);
        cyc(1, 32'h40208233, 32'd0, 32'd9, 32'd9, 0, 1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        cyc(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        chk("flush_gone", {31'd0, out_valid}, 32'd0);

        // Coverage sweep.
        cyc(1, 32'h0020C463, 32'd0, 32'd3, 32'd4, 1, 0);
        chk("blt_funct", {28'd0, alu_funct}, {28'd0, ALU_SLT});
        chk("blt_br", {31'd0, is_branch}, 32'd1);
        chk("blt_f3", {29'd0, br_funct3}, 32'd4);
        cyc(1, 32'h0020A463, 32'd0, 32'd3, 32'd4, 1, 0);
        chk("br010_ill", {31'd0, illegal}, 32'd1);
        chk("br010_a", alu_op_a, 32'd0);
        chk("br010_b", alu_op_b, 32'd0);
        cyc(1, 32'h00000097, 32'h100, 32'd7, 32'd7, 1, 0);
        chk("auipc_a", alu_op_a, 32'h100);
        chk("auipc_b", alu_op_b, 32'd0);
        cyc(1, 32'h000000EF, 32'hFFFFFFFC, 32'd7, 32'd7, 1, 0);
        chk("jal_a", alu_op_a, 32'hFFFFFFFC);
        chk("jal_b", alu_op_b, 32'd4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            cyc($urandom_range(0, 3) != 0,
                {f7, 18'($urandom), opc_tbl[$urandom_range(0, 9)]},
                $urandom, $urandom, $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        // Reset mid-stream: asynchronous clear between edges.
        cyc(1, 32'h002081B3, 32'd0, 32'd1, 32'd2, 0, 0);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_funct", {28'd0, alu_funct}, {28'd0, ALU_ADD});
        chk("arst_ready", {31'd0, in_ready}, 32'd0);
        mv = 1'b0; md = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc(1, 32'h40208233, 32'd0, 32'd10, 32'd3, 1, 0);
        cyc(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0);
        @(posedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
